// File: rtl/addsub_arb_pkg.sv
// Shared types and opcode constants for the add/sub arbiter and its clients.
package addsub_arb_pkg;

    typedef enum logic {EMPTY, FULL} rsp_state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    always_comb begin : search
        int            c;
        logic [IDW-1:0] cand;
        logic          found;
        gnt   = '0;
        idx   = '0;
        c     = 0;
        cand  = '0;
        found = 1'b0;
        if (en) begin
            for (int i = 0; i < NREQ; i++) begin
                c    = (int'(ptr) + i) % NREQ;
                cand = c[IDW-1:0];
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    idx       = cand;
                end
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// One shared 8-bit add/sub datapath, round-robin arbitrated, with a single registered
// response entry that can drain and reload on the same edge.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dataa,
    input  logic [NREQ*WIDTH-1:0] req_datab,
    input  logic [NREQ-1:0]       req_add_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  busy
);

    rsp_state_t       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             can_issue;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gidx;
    logic             xfer;
    logic [WIDTH-1:0] opa, opb, alu;

    assign can_issue = (state_q == EMPTY) || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (can_issue),
        .gnt (gnt),
        .idx (gidx)
    );

    // Grants are suppressed while reset is asserted so no requester sees a lost accept.
    assign req_ready = rst ? '0 : gnt;
    assign xfer      = |gnt;

    assign opa = req_dataa[gidx*WIDTH +: WIDTH];
    assign opb = req_datab[gidx*WIDTH +: WIDTH];

    always_comb begin
        alu = '0;
        case (req_add_sub[gidx])
            OP_ADD:  alu = opa + opb;
            OP_SUB:  alu = opa - opb;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        res_d   = res_q;
        if (xfer) begin
            state_d = FULL;
            id_d    = gidx;
            res_d   = alu;
            ptr_d   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign busy       = (state_q == FULL);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized and directed checks of addsub_arbiter against a behavioural response-slot model.
module tb_addsub_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dataa;
    logic [NREQ*WIDTH-1:0] req_datab;
    logic [NREQ-1:0]       req_add_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  busy;

    addsub_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .req_add_sub (req_add_sub),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: the single response slot and the next-search start index.
    bit m_full;
    int m_id;
    int m_res;
    int m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_alu(input int g);
        int a, b;
        a = int'(req_dataa[g*WIDTH +: WIDTH]);
        b = int'(req_datab[g*WIDTH +: WIDTH]);
        if (req_add_sub[g]) return (a + b) % 256;
        return (a - b + 256) % 256;
    endfunction

    // Check outputs mid-low-phase, clock once, advance the model, return at the next negedge.
    task automatic step();
        int g;
        int r;
        #1;
        g = exp_grant();
        check_eq("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check_eq("busy", 32'(busy), 32'(m_full));
        check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
        check_eq("rsp_result", 32'(rsp_result), 32'(m_res));
        r = (g >= 0) ? exp_alu(g) : 0;
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_id = 0; m_res = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_full = 1; m_id = g; m_res = r; m_ptr = (g + 1) % NREQ;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
        req_dataa[i*WIDTH +: WIDTH] = a;
        req_datab[i*WIDTH +: WIDTH] = b;
        req_add_sub[i]              = op;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; req_valid = '0; req_dataa = '0; req_datab = '0;
        req_add_sub = '0; rsp_ready = 1'b0;
        m_full = 0; m_id = 0; m_res = 0; m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;
        step();

        // Single add from requester 0.
        set_req(0, 8'h12, 8'h05, 1'b1);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        #1 check_eq("plan_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        #1 check_eq("plan_add", 32'(rsp_result), 32'h17);
        check_eq("plan_add_id", 32'(rsp_id), 32'h0);
        step();

        // All four streaming with consumer always ready.
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 16), 8'(i + 1), 1'b1);
        req_valid = 4'b1111;
        repeat (6) step();

        // Backpressure for three cycles, then drain and accept together.
        rsp_ready = 1'b0;
        repeat (3) step();
        rsp_ready = 1'b1;
        step();

        // Wrap-around arithmetic.
        req_valid = 4'b0000;
        step();
        set_req(2, 8'hFF, 8'h01, 1'b1);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        #1 check_eq("plan_wrap_add", 32'(rsp_result), 32'h00);
        set_req(3, 8'h00, 8'h01, 1'b0);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        #1 check_eq("plan_wrap_sub", 32'(rsp_result), 32'hFF);
        check_eq("plan_wrap_id", 32'(rsp_id), 32'h3);
        step();

        // Fairness: grant 1 to put ptr at 2, then 1 and 3 contend.
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        #1 check_eq("plan_fair_first", 32'(req_ready), 32'h8);
        repeat (3) step();

        // Reset while a result is pending.
        req_valid = 4'b1111; rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 4'b0000;
        #1 check_eq("plan_rst_valid", 32'(rsp_valid), 32'h0);
        step();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        #1 check_eq("plan_rst_ptr", 32'(req_ready), 32'h1);
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            req_valid   = 4'($urandom_range(0, 15));
            req_dataa   = $urandom;
            req_datab   = $urandom;
            req_add_sub = 4'($urandom_range(0, 15));
            rsp_ready   = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 8-bit add/subtract datapath between NREQ requesters using round-robin arbitration.
- Each requester presents operands and an opcode with a valid/ready handshake.
- The winning request is computed, and the result is returned on a single shared response channel tagged with the requester ID.
- The response channel holds one registered entry with backpressure. It sits between client blocks and the shared arithmetic resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width.
- IDW, $clog2(NREQ), requester ID width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
- req_dataa  in  NREQ*WIDTH  packed operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_datab  in  NREQ*WIDTH  packed operand B, same packing.
- req_add_sub  in  NREQ  1 = add, 0 = subtract (A-B).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_result  out  WIDTH  result, modulo 2^WIDTH.
- busy  out  1  high while the response entry is occupied.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - Round-robin pointer = 0, FSM = EMPTY.
  - req_ready is 0 during any cycle rst is high.
- FSM:
  - EMPTY: output entry free.
  - FULL: entry holds an unaccepted result.
  - busy = (state==FULL). rsp_valid = (state==FULL).
- Accept condition: can_issue = (state==EMPTY) || rsp_ready. This is a full-throughput pipeline: a new accept is allowed in the same cycle the held result drains.
- Arbitration (combinational, same cycle):
  - If can_issue and any req_valid is set, grant the first valid index searching from ptr upward with wrap-around (ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1).
  - req_ready[g]=1 only for the granted index g. All other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not depend on req_ready to raise valid.
- On transfer (req_valid[g] & req_ready[g]) at edge T:
  - rsp_result <= add_sub ? A+B : A-B, truncated to WIDTH, carry/borrow discarded.
  - rsp_id <= g. state <= FULL. ptr <= (g+1) mod NREQ.
  - Result is visible at T+1: single-cycle latency from accept to rsp_valid.
- FULL with rsp_ready=1 and no new transfer: state <= EMPTY. rsp_result and rsp_id hold their last values.
- FULL with rsp_ready=0: rsp_valid, rsp_id and rsp_result are held stable and all req_ready=0.
- No transfer in a cycle: ptr unchanged.
- Fairness: every continuously asserted requester is granted within NREQ transfers.
- Simultaneous drain + accept: the old result is consumed and the new result is loaded in the same edge. rsp_valid stays 1.
- Reset mid-operation: a pending result is discarded without a response, and the requester is not re-notified.
- Wrap-around arithmetic: 8'hFF+8'h01 = 8'h00; 8'h00-8'h01 = 8'hFF.

Decomposition:
- Package addsub_arb_pkg holds:
  - typedef enum logic {EMPTY, FULL} rsp_state_t.
  - Opcode constants OP_ADD=1'b1, OP_SUB=1'b0.
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant plus encoded index.
  - Purely combinational, reusable for other shared resources.
- The add/sub operation is inline in the top module. It is not a separate module.

Test Plan:
- Reset, then single request: req_valid=0001, A=8'h12, B=8'h05, add -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8'h17.
- All four valid continuously with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. rsp_id follows 0,1,2,3 one cycle later; one result per cycle.
- Backpressure: result pending, rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000 and rsp outputs stable for all 3 cycles. When rsp_ready=1, the next grant goes to ptr and the drain + accept occur in the same cycle.
- Wrap arithmetic: requester 2, 8'hFF+8'h01 -> 8'h00. Requester 3, 8'h00-8'h01 sub -> 8'hFF, rsp_id=3.
- Pointer fairness: requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1, then 3.
- Reset mid-operation: rsp_valid=1 and rst=1 for one cycle -> next cycle rsp_valid=0, busy=0, ptr=0, and req_ready=0 during the reset cycle.
